// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the decode/issue stage.
//   - ALUCTRL_* codes understood by the combinational ALU
//   - RV32I major opcode constants
//   - immediate-format enum, buffered-entry struct and small decode helpers
package alu_issue_pkg;

  localparam int XLEN_P   = 32;
  localparam int CTRL_W_P = 5;

  localparam logic [4:0] ALUCTRL_ADD   = 5'd0;
  localparam logic [4:0] ALUCTRL_SUB   = 5'd1;
  localparam logic [4:0] ALUCTRL_SLL   = 5'd2;
  localparam logic [4:0] ALUCTRL_SLT   = 5'd3;
  localparam logic [4:0] ALUCTRL_SLTU  = 5'd4;
  localparam logic [4:0] ALUCTRL_XOR   = 5'd5;
  localparam logic [4:0] ALUCTRL_SRL   = 5'd6;
  localparam logic [4:0] ALUCTRL_SRA   = 5'd7;
  localparam logic [4:0] ALUCTRL_OR    = 5'd8;
  localparam logic [4:0] ALUCTRL_AND   = 5'd9;
  localparam logic [4:0] ALUCTRL_BEQ   = 5'd10;
  localparam logic [4:0] ALUCTRL_BNE   = 5'd11;
  localparam logic [4:0] ALUCTRL_BLT   = 5'd12;
  localparam logic [4:0] ALUCTRL_BGE   = 5'd13;
  localparam logic [4:0] ALUCTRL_BLTU  = 5'd14;
  localparam logic [4:0] ALUCTRL_BGEU  = 5'd15;
  localparam logic [4:0] ALUCTRL_JAL   = 5'd16;
  localparam logic [4:0] ALUCTRL_JALR  = 5'd17;
  localparam logic [4:0] ALUCTRL_AUIPC = 5'd18;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5,
    IMM_SH   = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic [CTRL_W_P-1:0] alu_ctrl;
    logic                immsrc;
    logic                pcsrc;
    logic [XLEN_P-1:0]   imm;
    logic [XLEN_P-1:0]   pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                illegal;
  } issue_entry_t;

  // Build the immediate for a given format; everything sign-extends from inst[31].
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_SH:  imm = {27'd0, inst[24:20]};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // Map funct3 (plus the alternate bit, inst[30]) to an ALU operation.
  // Callers only pass alt=1 where SUB/SRA are legal.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  op = ALUCTRL_SLL;
      3'b010:  op = ALUCTRL_SLT;
      3'b011:  op = ALUCTRL_SLTU;
      3'b100:  op = ALUCTRL_XOR;
      3'b101:  op = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  op = ALUCTRL_OR;
      3'b111:  op = ALUCTRL_AND;
      default: op = ALUCTRL_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: combinational RV32I instruction -> ALU control decoder.
//   inst      in   instruction word
//   alu_ctrl  out  ALUCTRL_* code
//   immsrc    out  0 = rs2 operand, 1 = immediate
//   pcsrc     out  0 = rs1 operand, 1 = pc
//   imm       out  sign-extended immediate (0 when illegal)
//   rs1/rs2/rd out register indices
//   illegal   out  undecodable instruction
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  alu_ctrl,
  output logic        immsrc,
  output logic        pcsrc,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_e   fmt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  // Opcode/funct decode into control fields and immediate format.
  always_comb begin
    alu_ctrl = ALUCTRL_ADD;
    immsrc   = 1'b0;
    pcsrc    = 1'b0;
    fmt      = IMM_NONE;
    illegal  = 1'b0;
    rs1      = inst[19:15];
    rs2      = inst[24:20];
    rd       = inst[11:7];
    case (opcode)
      OP_R: begin
        // funct7 0100000 is only meaningful for SUB and SRA.
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          alu_ctrl = alu_op(f3, inst[30]);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        // inst[30] only selects SRAI; ADDI with inst[30] set stays ADD.
        immsrc   = 1'b1;
        alu_ctrl = alu_op(f3, (f3 == 3'b101) && inst[30]);
        fmt      = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SH : IMM_I;
      end
      OP_LOAD: begin
        immsrc = 1'b1;
        fmt    = IMM_I;
      end
      OP_STORE: begin
        immsrc = 1'b1;
        fmt    = IMM_S;
      end
      OP_BRANCH: begin
        fmt = IMM_B;
        case (f3)
          3'b000:  alu_ctrl = ALUCTRL_BEQ;
          3'b001:  alu_ctrl = ALUCTRL_BNE;
          3'b100:  alu_ctrl = ALUCTRL_BLT;
          3'b101:  alu_ctrl = ALUCTRL_BGE;
          3'b110:  alu_ctrl = ALUCTRL_BLTU;
          3'b111:  alu_ctrl = ALUCTRL_BGEU;
          default: illegal  = 1'b1;
        endcase
      end
      OP_JAL: begin
        alu_ctrl = ALUCTRL_JAL;
        pcsrc    = 1'b1;
        immsrc   = 1'b1;
        fmt      = IMM_J;
      end
      OP_JALR: begin
        alu_ctrl = ALUCTRL_JALR;
        immsrc   = 1'b1;
        fmt      = IMM_I;
      end
      OP_LUI: begin
        // rs1 forced to x0 so the ALU computes 0 + imm.
        rs1    = 5'd0;
        immsrc = 1'b1;
        fmt    = IMM_U;
      end
      OP_AUIPC: begin
        alu_ctrl = ALUCTRL_AUIPC;
        pcsrc    = 1'b1;
        immsrc   = 1'b1;
        fmt      = IMM_U;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal entries carry a neutral ADD with zero immediate and operand selects.
    if (illegal) begin
      alu_ctrl = ALUCTRL_ADD;
      immsrc   = 1'b0;
      pcsrc    = 1'b0;
      imm      = 32'd0;
    end else begin
      imm = imm_gen(inst, fmt);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage with a 2-entry skid buffer.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   fetch handshake (in_ready registered: not full)
//   in_inst, in_pc      instruction and its PC
//   flush               drop all buffered entries and the current input beat
//   out_valid/out_ready execute handshake
//   out_*               decoded fields of the head entry, driven from flops
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_immsrc,
  output logic              out_pcsrc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  // head_q is the entry presented on out_*; skid_q holds the second entry.
  issue_entry_t head_q, head_d;
  issue_entry_t skid_q, skid_d;
  issue_entry_t dec_ent;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push, pop;

  alu_issue_dec u_dec (
    .inst     (in_inst),
    .alu_ctrl (dec_ent.alu_ctrl),
    .immsrc   (dec_ent.immsrc),
    .pcsrc    (dec_ent.pcsrc),
    .imm      (dec_ent.imm),
    .rs1      (dec_ent.rs1),
    .rs2      (dec_ent.rs2),
    .rd       (dec_ent.rd),
    .illegal  (dec_ent.illegal)
  );
  assign dec_ent.pc = in_pc;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Next-state for the buffer; flush wins over any push/pop this cycle.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = dec_ent;
          end else begin
            skid_d = dec_ent;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = skid_q;
          count_d = count_q - 2'd1;
        end
        // Only reachable at count 1: the new entry replaces the departing head.
        2'b11: begin
          head_d = dec_ent;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  // Buffer state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_alu_ctrl = head_q.alu_ctrl;
  assign out_immsrc   = head_q.immsrc;
  assign out_pcsrc    = head_q.pcsrc;
  assign out_imm      = head_q.imm;
  assign out_pc       = head_q.pc;
  assign out_rs1      = head_q.rs1;
  assign out_rs2      = head_q.rs2;
  assign out_rd       = head_q.rd;
  assign out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_alu_ctrl;
  logic        out_immsrc;
  logic        out_pcsrc;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  bit mon_en = 1'b0;
  issue_entry_t sb[$];

  alu_issue #(.XLEN(32), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl), .out_immsrc(out_immsrc),
    .out_pcsrc(out_pcsrc), .out_imm(out_imm), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic issue_entry_t dut_view();
    issue_entry_t e;
    e.alu_ctrl = out_alu_ctrl; e.immsrc = out_immsrc; e.pcsrc = out_pcsrc;
    e.imm = out_imm; e.pc = out_pc; e.rs1 = out_rs1; e.rs2 = out_rs2;
    e.rd = out_rd; e.illegal = out_illegal;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference decode straight from the RV32I rules, using signed arithmetic.
  function automatic issue_entry_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    issue_entry_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int simm;
    logic [4:0] base [8];
    logic [4:0] br [8];
    base = '{ALUCTRL_ADD, ALUCTRL_SLL, ALUCTRL_SLT, ALUCTRL_SLTU,
             ALUCTRL_XOR, ALUCTRL_SRL, ALUCTRL_OR, ALUCTRL_AND};
    br   = '{ALUCTRL_BEQ, ALUCTRL_BNE, 5'd31, 5'd31,
             ALUCTRL_BLT, ALUCTRL_BGE, ALUCTRL_BLTU, ALUCTRL_BGEU};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '0;
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.alu_ctrl = ALUCTRL_ADD;
    simm = 0;
    if (op == OP_R) begin
      if (f7 == 7'h00) e.alu_ctrl = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu_ctrl = ALUCTRL_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu_ctrl = ALUCTRL_SRA;
      else e.illegal = 1'b1;
    end else if (op == OP_IMM) begin
      e.immsrc = 1'b1;
      e.alu_ctrl = (f3 == 3'd5 && i[30]) ? ALUCTRL_SRA : base[f3];
      if (f3 == 3'd1 || f3 == 3'd5) simm = int'(i[24:20]);
      else simm = $signed(i[31:20]);
    end else if (op == OP_LOAD || op == OP_JALR) begin
      e.immsrc = 1'b1;
      if (op == OP_JALR) e.alu_ctrl = ALUCTRL_JALR;
      simm = $signed(i[31:20]);
    end else if (op == OP_STORE) begin
      e.immsrc = 1'b1;
      simm = $signed({i[31:25], i[11:7]});
    end else if (op == OP_BRANCH) begin
      if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1'b1;
      else e.alu_ctrl = br[f3];
      simm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    end else if (op == OP_JAL) begin
      e.alu_ctrl = ALUCTRL_JAL; e.pcsrc = 1'b1; e.immsrc = 1'b1;
      simm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
    end else if (op == OP_LUI || op == OP_AUIPC) begin
      e.immsrc = 1'b1;
      simm = int'(i[31:12]) * 4096;
      if (op == OP_LUI) e.rs1 = 5'd0;
      else begin e.alu_ctrl = ALUCTRL_AUIPC; e.pcsrc = 1'b1; end
    end else begin
      e.illegal = 1'b1;
    end
    e.imm = e.illegal ? 32'd0 : 32'(simm);
    return e;
  endfunction

  // One cycle of stimulus: check handshake state from the model, then drive the next beat.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    int push, pop;
    @(negedge clk); #1;
    chk("in_ready", 64'(in_ready), 64'(model_cnt < 2));
    chk("out_valid", 64'(out_valid), 64'(model_cnt != 0));
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    if (fl) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      push = (v && model_cnt < 2) ? 1 : 0;
      pop  = (model_cnt > 0 && rdy) ? 1 : 0;
      if (push == 1) sb.push_back(ref_decode(inst, pc));
      model_cnt = model_cnt + push - pop;
    end
  endtask

  // Monitor: pop the scoreboard on every output handshake and check stall stability.
  initial begin
    issue_entry_t held;
    issue_entry_t exp;
    bit held_v;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk); #2;
      if (!mon_en || !rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v && out_valid) chk("stall_stable", 64'(dut_view()), 64'(held));
        held_v = 1'b0;
        if (out_valid && !flush) begin
          if (out_ready) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 64'(1), 64'(0));
            end else begin
              exp = sb.pop_front();
              n_checks++;
              if (dut_view() !== exp) begin
                n_fail++;
                $display("FAIL entry actual=%h expected=%h", dut_view(), exp);
              end
            end
          end else begin
            held = dut_view();
            held_v = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [9];
    logic [31:0] ri;
    int k;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_data", 64'(dut_view()), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed decodes with out_ready held high
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    step(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
    chk("addi_ctrl", 64'(out_alu_ctrl), 64'(ALUCTRL_ADD));
    chk("addi_imm", 64'(out_imm), 64'(5));
    chk("addi_sel", 64'({out_immsrc, out_pcsrc, out_rd}), 64'({1'b1, 1'b0, 5'd1}));
    step(1'b1, 32'h4032D293, 32'h108, 1'b1, 1'b0);
    chk("sub_ctrl", 64'(out_alu_ctrl), 64'(ALUCTRL_SUB));
    chk("sub_regs", 64'({out_immsrc, out_rs1, out_rs2, out_rd}), 64'({1'b0, 5'd1, 5'd2, 5'd3}));
    step(1'b1, 32'hFE208CE3, 32'h10C, 1'b1, 1'b0);
    chk("srai", 64'({out_alu_ctrl, out_imm}), 64'({ALUCTRL_SRA, 32'd3}));
    step(1'b1, 32'h0000006F, 32'h110, 1'b1, 1'b0);
    chk("beq", 64'({out_alu_ctrl, out_immsrc, out_imm}), 64'({ALUCTRL_BEQ, 1'b0, 32'hFFFFFFF8}));
    step(1'b1, 32'hFFFFFFFF, 32'h114, 1'b1, 1'b0);
    chk("jal", 64'({out_alu_ctrl, out_pcsrc}), 64'({ALUCTRL_JAL, 1'b1}));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("illegal", 64'({out_illegal, out_alu_ctrl, out_imm}), 64'({1'b1, ALUCTRL_ADD, 32'd0}));

    // Back-pressure: three back-to-back pushes with out_ready low, then release
    step(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush with two entries buffered and a live input beat
    step(1'b1, 32'h00400293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00500313, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00600393, 32'h308, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic over all opcode classes
    for (int n = 0; n < 1500; n++) begin
      ri = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) ri[6:0] = ops[k];
      if (ri[6:0] == OP_R) begin
        k = $urandom_range(0, 3);
        ri[31:25] = (k == 0) ? 7'h20 : ((k == 1) ? 7'($urandom) : 7'h00);
      end
      step(1'($urandom_range(0, 3) != 0), ri, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Drain and confirm everything expected was emitted
    for (int n = 0; n < 4; n++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk); #3;
    chk("drain_empty", 64'(sb.size()), 64'(0));

    // Mid-stream asynchronous reset, asserted away from any clock edge
    step(1'b1, 32'h00700413, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00800493, 32'h404, 1'b0, 1'b0);
    @(negedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_data", 64'(dut_view()), 64'(0));
    sb.delete();
    model_cnt = 0;
    @(negedge clk); #1; rst_n = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 32'h00500093, 32'h500, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk); #3;
    chk("post_rst_drain", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that produces the operand-select and control fields consumed by the team's combinational ALU: alu_ctrl, immediate, immsrc and pcsrc.
- Takes RV32I instructions plus PC from fetch and decodes them into ALU control, sign-extended immediate and register indices.
- Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides, so fetch and execute decouple without combinational ready paths.

Parameters:
- XLEN, 32, datapath width of inst/pc/imm
- CTRL_W, 5, width of alu_ctrl; encodings come from the shared ALUCTRL definitions

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered (not full)
- in_inst  input  XLEN  instruction word
- in_pc  input  XLEN  PC of in_inst
- flush  input  1  discard all buffered entries (branch/jump redirect)
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head
- out_alu_ctrl  output  CTRL_W  ALUCTRL_* code
- out_immsrc  output  1  0 = rs2, 1 = imm
- out_pcsrc  output  1  0 = rs1, 1 = pc
- out_imm  output  XLEN  sign-extended immediate
- out_pc  output  XLEN  PC carried with the entry
- out_rs1, out_rs2, out_rd  output  5 each  register indices
- out_illegal  output  1  undecodable instruction

Behaviour:
- Reset (async, rst_n low): both entries invalid; out_valid=0, in_ready=1; all out_* data = 0.
- Accept when in_valid && in_ready; pop when out_valid && out_ready. Decode is combinational on input; the result is written into the buffer.
- Latency: an accepted instruction appears on out_* at the next rising edge when the buffer was empty.
- Order is strictly FIFO. Count 0..2. in_ready = (count < 2) from registered state only.
- A simultaneous push and pop at count 2 is impossible (in_ready=0). At count 1, push+pop keeps count 1.
- out_* data are stable while out_valid && !out_ready.
- Flush takes priority over push/pop in the same cycle: count becomes 0, out_valid=0 next cycle, the input beat is dropped, and in_ready=1 next cycle.
- Reset mid-operation: immediate clear, no partial output.

Decode by opcode inst[6:0]:
- 0110011 (R): funct3/inst[30] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; immsrc=0, pcsrc=0.
- 0010011 (I-ALU): same selection with immsrc=1, I-imm. inst[30] is used only for SRLI/SRAI; ADDI never maps to SUB. Shift imm = shamt.
- 0000011 load / 0100011 store: ADD, immsrc=1; I-imm or S-imm respectively.
- 1100011: funct3 000/001/100/101/110/111 map to BEQ/BNE/BLT/BGE/BLTU/BGEU; immsrc=0, pcsrc=0; B-imm. funct3 010/011 are illegal.
- 1101111: JAL, pcsrc=1, immsrc=1, J-imm.
- 1100111: JALR, pcsrc=0, immsrc=1, I-imm.
- 0110111 LUI: ADD, rs1 forced to 0, immsrc=1, U-imm.
- 0010111 AUIPC: AUIPC, pcsrc=1, immsrc=1, U-imm.
- All other opcodes, or invalid funct7 on R-type: out_illegal=1, alu_ctrl=ALUCTRL_ADD, imm=0. The entry still flows in order.
- Immediates are sign-extended from inst[31]; B/J bit 0 = 0; U low 12 bits = 0.

Decomposition:
- Shared package holds: ALUCTRL_* codes (the existing ALU control definitions), RV32I opcode constants, and the imm-format enum.
- Natural sub-module: alu_issue_dec, a combinational inst→fields decoder. The top holds the skid buffer and handshake.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, ALUCTRL_ADD, imm=5, immsrc=1, pcsrc=0, rd=1.
- 0x402081B3 (sub x3,x1,x2) → ALUCTRL_SUB, immsrc=0, rs1=1, rs2=2, rd=3; then 0x4032D293 (srai x5,x5,3) → ALUCTRL_SRA, imm=3.
- 0xFE208CE3 (beq x1,x2,-8) → ALUCTRL_BEQ, imm=0xFFFFFFF8, immsrc=0; 0x0000006F (jal x0,0) → ALUCTRL_JAL, pcsrc=1.
- out_ready=0, push 3 instructions back-to-back → in_ready drops after 2 accepted; raise out_ready → entries emerge in order, in_ready returns 1 the cycle after the first pop.
- 2 entries buffered, flush=1 with in_valid=1 → next cycle out_valid=0, count 0, the input beat is not emitted.
- 0xFFFFFFFF → out_illegal=1, alu_ctrl=ALUCTRL_ADD, imm=0. Assert rst_n low mid-stream → outputs are 0 and in_ready=1 without waiting for a clock edge.
